axis_dac_burst_sequencer: RTL



---
 rtl/axis_dac_seq_pkg.sv | 10 +
 rtl/axis_dac_seq_gain.sv | 29 ++
 rtl/axis_dac_burst_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/axis_dac_seq_pkg.sv
// axis_dac_seq_pkg: FSM states and gain helpers shared by axis_dac_burst_sequencer and axis_dac_seq_gain
package axis_dac_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PLAY = 2'd2} state_t;
    localparam int GAIN_FRAC = 14;
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
    endfunction
endpackage

// File: rtl/axis_dac_seq_gain.sv
// axis_dac_seq_gain: registered Q1.14 gain stage (multiply, round, saturate); used when AXIS_DAC_SEQ_GAIN_EN is defined
module axis_dac_seq_gain
    import axis_dac_seq_pkg::*;
#(
    parameter int DW = 14
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_sample,
    input  logic [15:0]   gain,
    output logic          out_valid,
    output logic [DW-1:0] out_sample
);
    logic signed [DW+15:0] prod;
    logic signed [63:0] rounded;
    assign prod = (DW+16)'($signed(in_sample)) * (DW+16)'($signed(gain));
    assign rounded = (64'(prod) + (64'sd1 <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_sample <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_sample <= DW'(saturate(rounded, DW));
        end
    end
endmodule

// File: rtl/axis_dac_burst_sequencer.sv
// axis_dac_burst_sequencer: triggered BRAM waveform bursts into a DAC AXI-Stream, idle level otherwise.
// Define AXIS_DAC_SEQ_GAIN_EN to add the cfg_gain port and a gain pipeline stage.
module axis_dac_burst_sequencer
    import axis_dac_seq_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int BRAM_DATA_WIDTH  = 16,
    parameter int BRAM_ADDR_WIDTH  = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_length,
    input  logic [CNTR_WIDTH-1:0]       cfg_repeats,
    input  logic [DAC_DATA_WIDTH-1:0]   cfg_idle,
`ifdef AXIS_DAC_SEQ_GAIN_EN
    input  logic [15:0]                 cfg_gain,
`endif
    input  logic                        arm,
    input  logic                        trig,
    output logic                        sts_busy,
    output logic [CNTR_WIDTH-1:0]       sts_passes,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);
    localparam int EXT = AXIS_TDATA_WIDTH - DAC_DATA_WIDTH;
    state_t state, state_nxt;
    logic trig_q, trig_edge, beat, play, wrap, done, src_play, unused_rd;
    logic [BRAM_ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [CNTR_WIDTH-1:0] passes_nxt, passes_inc;
    logic [DAC_DATA_WIDTH-1:0] src;
    assign trig_edge = trig & ~trig_q;
    assign beat = m_axis_tvalid & m_axis_tready;
    assign play = (state == PLAY) & arm;
    assign wrap = ptr == cfg_length;
    assign passes_inc = &sts_passes ? sts_passes : sts_passes + 1'b1;
    assign done = wrap && cfg_repeats != '0 && passes_inc == cfg_repeats;
    assign sts_busy = state != IDLE;
    // ptr names the sample loaded on the next beat; the BRAM is fed the address needed one cycle later, so a stall re-reads it
    assign bram_porta_addr = state == PLAY ? ptr_nxt : '0;
    assign unused_rd = ^bram_porta_rddata[BRAM_DATA_WIDTH-1:DAC_DATA_WIDTH];
    always_comb begin
        state_nxt = state;
        ptr_nxt = ptr;
        passes_nxt = sts_passes;
        case (state)
            IDLE: begin
                ptr_nxt = '0;
                state_nxt = arm ? ARMED : IDLE;
            end
            ARMED: begin
                ptr_nxt = '0;
                if (!arm) state_nxt = IDLE;
                else if (trig_edge) begin
                    state_nxt = PLAY;
                    passes_nxt = '0;
                end
            end
            PLAY: begin
                if (!arm) state_nxt = IDLE;
                else if (beat) begin
                    ptr_nxt = wrap ? '0 : ptr + 1'b1;
                    passes_nxt = wrap ? passes_inc : sts_passes;
                    state_nxt = done ? ARMED : PLAY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`ifdef AXIS_DAC_SEQ_GAIN_EN
    logic g_valid;
    logic [DAC_DATA_WIDTH-1:0] g_sample;
    axis_dac_seq_gain #(.DW(DAC_DATA_WIDTH)) u_gain (
        .aclk      (aclk),
        .areset    (areset),
        .en        (beat),
        .in_valid  (play),
        .in_sample (bram_porta_rddata[DAC_DATA_WIDTH-1:0]),
        .gain      (cfg_gain),
        .out_valid (g_valid),
        .out_sample(g_sample)
    );
    // the last scaled sample drains after the FSM has left PLAY; an abort drops it
    assign src_play = g_valid & arm;
    assign src = g_sample;
`else
    assign src_play = play;
    assign src = bram_porta_rddata[DAC_DATA_WIDTH-1:0];
`endif
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            trig_q <= 1'b0;
            ptr <= '0;
            sts_passes <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            state <= state_nxt;
            trig_q <= trig;
            ptr <= ptr_nxt;
            sts_passes <= passes_nxt;
            m_axis_tvalid <= 1'b1;
            if (beat || !m_axis_tvalid)
                m_axis_tdata <= src_play ? {{EXT{src[DAC_DATA_WIDTH-1]}}, src}
                                         : {{EXT{cfg_idle[DAC_DATA_WIDTH-1]}}, cfg_idle};
        end
    end
endmodule
